// File: rtl/dat_l2_initiator_if.sv
// Cache/L2 handshake bundle for the L2 initiator.
// The master modport is the initiator's view; the slave modport is the
// view of whatever sits on the other side (cache plus L2).
interface dat_l2_initiator_if #(
    parameter int B = 9,
    parameter int W = 7
);
    // Cache refill channel
    logic                 refill_req_valid;
    logic                 refill_req_ready;
    logic [29:0]          refill_addr;
    logic                 refill_valid;
    logic                 refill_accept;
    logic [(1 << B)-1:0]  refill_line;

    // Cache writeback channel
    logic                 wb_req_valid;
    logic                 wb_req_ready;
    logic [29:0]          wb_addr;
    logic [(1 << B)-1:0]  wb_line;

    // L2 read channel
    logic                 rd_addr_to_l2_valid;
    logic                 rd_addr_to_l2_ready;
    logic [29:0]          rd_addr_to_l2;
    logic                 data_from_l2_valid;
    logic                 data_from_l2_ready;
    logic [(1 << W)-1:0]  data_from_l2;

    // L2 write channel
    logic                 wr_to_l2_valid;
    logic                 wr_to_l2_ready;
    logic [29:0]          wr_addr_to_l2;
    logic [(1 << W)-1:0]  data_to_l2;
    logic                 wr_control_to_l2;
    logic                 wr_complete;

    // Sticky protocol-violation flag
    logic                 proto_err;

    modport master (
        input  refill_req_valid,
        output refill_req_ready,
        input  refill_addr,
        output refill_valid,
        input  refill_accept,
        output refill_line,
        input  wb_req_valid,
        output wb_req_ready,
        input  wb_addr,
        input  wb_line,
        output rd_addr_to_l2_valid,
        input  rd_addr_to_l2_ready,
        output rd_addr_to_l2,
        input  data_from_l2_valid,
        output data_from_l2_ready,
        input  data_from_l2,
        output wr_to_l2_valid,
        input  wr_to_l2_ready,
        output wr_addr_to_l2,
        output data_to_l2,
        output wr_control_to_l2,
        input  wr_complete,
        output proto_err
    );

    modport slave (
        output refill_req_valid,
        input  refill_req_ready,
        output refill_addr,
        input  refill_valid,
        output refill_accept,
        input  refill_line,
        output wb_req_valid,
        input  wb_req_ready,
        output wb_addr,
        output wb_line,
        input  rd_addr_to_l2_valid,
        output rd_addr_to_l2_ready,
        input  rd_addr_to_l2,
        output data_from_l2_valid,
        input  data_from_l2_ready,
        output data_from_l2,
        input  wr_to_l2_valid,
        output wr_to_l2_ready,
        input  wr_addr_to_l2,
        input  data_to_l2,
        input  wr_control_to_l2,
        output wr_complete,
        input  proto_err
    );
endinterface

// File: rtl/dat_l2_initiator.sv
// L2 initiator: turns cache line refills and writebacks into L2 bursts.
// Independent read and write engines; a refill to a line that is being
// written back is held off until the writeback has been committed.
// Every L2-side output is a decode of registered state only.
module dat_l2_initiator #(
    parameter int B = 9,
    parameter int W = 7
) (
    input logic             clk,
    input logic             rstn,
    dat_l2_initiator_if.master bus
);
    localparam int LINE  = 1 << B;
    localparam int BEAT  = 1 << W;
    localparam int CW    = B - W;
    localparam int BURST = 1 << CW;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_HOLD} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT} wr_state_t;

    rd_state_t         rd_state;
    wr_state_t         wr_state;
    logic [CW-1:0]     rd_cnt;
    logic [CW-1:0]     wr_cnt;
    logic [29:0]       rd_base;
    logic [29:0]       wr_base;
    logic [LINE-1:0]   line_buf;
    logic [LINE-1:0]   wr_buf;
    logic              proto_err_q;

    logic [B-1:0]      rd_off;
    logic [B-1:0]      wr_off;
    logic              wb_take;
    logic              hazard;
    logic              refill_ready;
    logic              refill_take;

    // Bit offset of the current beat inside a line
    assign rd_off = {rd_cnt, {W{1'b0}}};
    assign wr_off = {wr_cnt, {W{1'b0}}};

    // A writeback is taken whenever the write engine is idle
    assign wb_take = bus.wb_req_valid && (wr_state == W_IDLE);

    // Refill must not overtake a writeback of the same line, whether the
    // writeback is already in flight or is being accepted this very cycle
    assign hazard = ((wr_state != W_IDLE) && (bus.refill_addr == wr_base)) ||
                    (wb_take && (bus.wb_addr == bus.refill_addr));

    assign refill_ready = (rd_state == R_IDLE) && !hazard;
    assign refill_take  = bus.refill_req_valid && refill_ready;

    // Cache-facing outputs
    assign bus.refill_req_ready = refill_ready;
    assign bus.refill_valid     = (rd_state == R_HOLD);
    assign bus.refill_line      = line_buf;
    assign bus.wb_req_ready     = (wr_state == W_IDLE);

    // L2 read-side outputs
    assign bus.rd_addr_to_l2_valid = (rd_state == R_ADDR);
    assign bus.rd_addr_to_l2       = rd_base;
    assign bus.data_from_l2_ready  = (rd_state != R_HOLD);

    // L2 write-side outputs
    assign bus.wr_to_l2_valid   = (wr_state == W_DATA);
    assign bus.wr_addr_to_l2    = wr_base;
    assign bus.data_to_l2       = wr_buf[wr_off +: BEAT];
    assign bus.wr_control_to_l2 = (wr_state == W_DATA) && (wr_cnt == '0);

    assign bus.proto_err = proto_err_q;

    // Read engine: latch refill address, issue it, gather beats, hold the line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
            rd_base  <= '0;
            line_buf <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (refill_take) begin
                        rd_base  <= bus.refill_addr;
                        rd_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (bus.rd_addr_to_l2_ready) begin
                        rd_cnt   <= '0;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.data_from_l2_valid) begin
                        line_buf[rd_off +: BEAT] <= bus.data_from_l2;
                        if (rd_cnt == LAST_BEAT) begin
                            rd_cnt   <= '0;
                            rd_state <= R_HOLD;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                R_HOLD: begin
                    if (bus.refill_accept) begin
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Write engine: latch dirty line, stream beats, wait for commit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state <= W_IDLE;
            wr_cnt   <= '0;
            wr_base  <= '0;
            wr_buf   <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (wb_take) begin
                        wr_base  <= bus.wb_addr;
                        wr_buf   <= bus.wb_line;
                        wr_cnt   <= '0;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.wr_to_l2_ready) begin
                        if (wr_cnt == LAST_BEAT) begin
                            wr_cnt   <= '0;
                            wr_state <= W_WAIT;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                W_WAIT: begin
                    if (bus.wr_complete) begin
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Sticky flag for read beats before the address phase ends or stray commits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            proto_err_q <= 1'b0;
        end else if ((bus.data_from_l2_valid &&
                      ((rd_state == R_IDLE) || (rd_state == R_ADDR))) ||
                     (bus.wr_complete && (wr_state != W_WAIT))) begin
            proto_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dat_l2_initiator.sv
// Directed bench for dat_l2_initiator: refill, writeback, hazard, concurrency,
// protocol error and mid-burst reset scenarios with hand-picked beat data.
module tb_dat_l2_initiator;
    localparam int B = 9;
    localparam int W = 7;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] rd_beats [4];
    logic [127:0] wb_beats [4];
    bit           ready_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    dat_l2_initiator_if #(.B(B), .W(W)) bus();

    dat_l2_initiator #(.B(B), .W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Safety net in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " refill_req_ready"}, bus.refill_req_ready, 1'b1);
        check_output({tag, " wb_req_ready"}, bus.wb_req_ready, 1'b1);
        check_output({tag, " data_from_l2_ready"}, bus.data_from_l2_ready, 1'b1);
        check_output({tag, " rd_addr_valid"}, bus.rd_addr_to_l2_valid, 1'b0);
        check_output({tag, " refill_valid"}, bus.refill_valid, 1'b0);
        check_output({tag, " wr_valid"}, bus.wr_to_l2_valid, 1'b0);
        check_output({tag, " wr_control"}, bus.wr_control_to_l2, 1'b0);
        check_output({tag, " proto_err"}, bus.proto_err, 1'b0);
        check_output({tag, " rd_addr"}, bus.rd_addr_to_l2, 30'h0);
        check_output({tag, " wr_addr"}, bus.wr_addr_to_l2, 30'h0);
        check_output({tag, " data_to_l2"}, bus.data_to_l2, 128'h0);
        check_output({tag, " refill_line"}, bus.refill_line, 512'h0);
    endtask

    task automatic accept_refill(input string tag, input logic [29:0] a);
        bus.refill_req_valid = 1'b1;
        bus.refill_addr      = a;
        #1;
        check_output({tag, " refill_req_ready"}, bus.refill_req_ready, 1'b1);
        tick();
        bus.refill_req_valid = 1'b0;
    endtask

    task automatic address_phase(input string tag, input logic [29:0] a);
        check_output({tag, " rd_addr_valid"}, bus.rd_addr_to_l2_valid, 1'b1);
        check_output({tag, " rd_addr"}, bus.rd_addr_to_l2, a);
        bus.rd_addr_to_l2_ready = 1'b1;
        tick();
        bus.rd_addr_to_l2_ready = 1'b0;
        check_output({tag, " rd_addr_valid after handshake"}, bus.rd_addr_to_l2_valid, 1'b0);
    endtask

    task automatic feed_read_beats(input int count);
        for (int k = 0; k < count; k++) begin
            bus.data_from_l2_valid = 1'b1;
            bus.data_from_l2       = rd_beats[k];
            tick();
        end
        bus.data_from_l2_valid = 1'b0;
        bus.data_from_l2       = '0;
    endtask

    task automatic finish_refill(input string tag);
        check_output({tag, " refill_valid"}, bus.refill_valid, 1'b1);
        check_output({tag, " refill_line"}, bus.refill_line,
                     {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        check_output({tag, " data_from_l2_ready in hold"}, bus.data_from_l2_ready, 1'b0);
        bus.refill_accept = 1'b1;
        tick();
        bus.refill_accept = 1'b0;
        check_output({tag, " refill_valid after accept"}, bus.refill_valid, 1'b0);
        check_output({tag, " data_from_l2_ready after accept"}, bus.data_from_l2_ready, 1'b1);
    endtask

    initial begin
        bus.refill_req_valid    = 1'b0;
        bus.refill_addr         = '0;
        bus.refill_accept       = 1'b0;
        bus.wb_req_valid        = 1'b0;
        bus.wb_addr             = '0;
        bus.wb_line             = '0;
        bus.rd_addr_to_l2_ready = 1'b0;
        bus.data_from_l2_valid  = 1'b0;
        bus.data_from_l2        = '0;
        bus.wr_to_l2_ready      = 1'b0;
        bus.wr_complete         = 1'b0;

        // Reset state
        #12;
        check_reset_values("reset");
        #10;
        rstn = 1'b1;
        tick();

        // Refill 0x100, beats arrive after seven idle cycles
        rd_beats[0] = 128'h00000000_11111111_22222222_33333333;
        rd_beats[1] = 128'h44444444_55555555_66666666_77777777;
        rd_beats[2] = 128'h88888888_99999999_AAAAAAAA_BBBBBBBB;
        rd_beats[3] = 128'hCCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF;
        accept_refill("rf1", 30'h100);
        address_phase("rf1", 30'h100);
        repeat (7) tick();
        check_output("rf1 refill_valid while waiting", bus.refill_valid, 1'b0);
        check_output("rf1 data_from_l2_ready while waiting", bus.data_from_l2_ready, 1'b1);
        feed_read_beats(4);
        repeat (2) tick();
        check_output("rf1 data_from_l2_ready held low", bus.data_from_l2_ready, 1'b0);
        finish_refill("rf1");

        // Writeback 0x200 with L2 write ready toggling
        wb_beats[0] = 128'hA0A0A0A0_00000000_00000000_00000001;
        wb_beats[1] = 128'hA1A1A1A1_00000000_00000000_00000002;
        wb_beats[2] = 128'hA2A2A2A2_00000000_00000000_00000003;
        wb_beats[3] = 128'hA3A3A3A3_00000000_00000000_00000004;
        bus.wb_req_valid = 1'b1;
        bus.wb_addr      = 30'h200;
        bus.wb_line      = {wb_beats[3], wb_beats[2], wb_beats[1], wb_beats[0]};
        #1;
        check_output("wb1 wb_req_ready", bus.wb_req_ready, 1'b1);
        tick();
        bus.wb_req_valid = 1'b0;
        begin
            int idx;
            idx = 0;
            for (int i = 0; i < 6; i++) begin
                bus.wr_to_l2_ready = ready_pat[i];
                check_output("wb1 wr_valid", bus.wr_to_l2_valid, 1'b1);
                check_output("wb1 wr_addr", bus.wr_addr_to_l2, 30'h200);
                check_output("wb1 data_to_l2", bus.data_to_l2, wb_beats[idx]);
                check_output("wb1 wr_control", bus.wr_control_to_l2, (idx == 0) ? 1'b1 : 1'b0);
                check_output("wb1 wb_req_ready busy", bus.wb_req_ready, 1'b0);
                tick();
                if (ready_pat[i]) idx++;
            end
        end
        bus.wr_to_l2_ready = 1'b0;
        check_output("wb1 wr_valid after 4 beats", bus.wr_to_l2_valid, 1'b0);
        repeat (2) tick();
        check_output("wb1 wb_req_ready waiting commit", bus.wb_req_ready, 1'b0);
        bus.wr_complete = 1'b1;
        tick();
        bus.wr_complete = 1'b0;
        check_output("wb1 wb_req_ready after commit", bus.wb_req_ready, 1'b1);
        check_output("wb1 proto_err", bus.proto_err, 1'b0);

        // Same-line refill and writeback at 0x300: writeback wins
        bus.refill_req_valid = 1'b1;
        bus.refill_addr      = 30'h300;
        bus.wb_req_valid     = 1'b1;
        bus.wb_addr          = 30'h300;
        #1;
        check_output("hz refill_req_ready same cycle", bus.refill_req_ready, 1'b0);
        check_output("hz wb_req_ready same cycle", bus.wb_req_ready, 1'b1);
        tick();
        bus.wb_req_valid = 1'b0;
        #1;
        check_output("hz refill_req_ready write busy", bus.refill_req_ready, 1'b0);
        check_output("hz wr_addr", bus.wr_addr_to_l2, 30'h300);
        bus.wr_to_l2_ready = 1'b1;
        repeat (4) tick();
        bus.wr_to_l2_ready = 1'b0;
        check_output("hz wr_valid after burst", bus.wr_to_l2_valid, 1'b0);
        check_output("hz refill_req_ready in wait", bus.refill_req_ready, 1'b0);
        bus.wr_complete = 1'b1;
        #1;
        check_output("hz refill_req_ready on commit cycle", bus.refill_req_ready, 1'b0);
        tick();
        bus.wr_complete = 1'b0;
        #1;
        check_output("hz refill_req_ready after commit", bus.refill_req_ready, 1'b1);
        check_output("hz rd_addr_valid before accept", bus.rd_addr_to_l2_valid, 1'b0);
        tick();
        bus.refill_req_valid = 1'b0;
        rd_beats[0] = 128'h30000000_00000000_00000000_00000000;
        rd_beats[1] = 128'h30000001_00000000_00000000_00000001;
        rd_beats[2] = 128'h30000002_00000000_00000000_00000002;
        rd_beats[3] = 128'h30000003_00000000_00000000_00000003;
        address_phase("hz", 30'h300);
        feed_read_beats(4);
        finish_refill("hz");

        // Refill 0x100 and writeback 0x400 accepted together, run concurrently
        wb_beats[0] = 128'hB0B0B0B0_B0B0B0B0_B0B0B0B0_B0B0B0B0;
        wb_beats[1] = 128'hB1B1B1B1_B1B1B1B1_B1B1B1B1_B1B1B1B1;
        wb_beats[2] = 128'hB2B2B2B2_B2B2B2B2_B2B2B2B2_B2B2B2B2;
        wb_beats[3] = 128'hB3B3B3B3_B3B3B3B3_B3B3B3B3_B3B3B3B3;
        rd_beats[0] = 128'hDEAD0000_00000000_00000000_0000BEEF;
        rd_beats[1] = 128'hDEAD0001_00000000_00000000_0001BEEF;
        rd_beats[2] = 128'hDEAD0002_00000000_00000000_0002BEEF;
        rd_beats[3] = 128'hDEAD0003_00000000_00000000_0003BEEF;
        bus.refill_req_valid = 1'b1;
        bus.refill_addr      = 30'h100;
        bus.wb_req_valid     = 1'b1;
        bus.wb_addr          = 30'h400;
        bus.wb_line          = {wb_beats[3], wb_beats[2], wb_beats[1], wb_beats[0]};
        #1;
        check_output("cc refill_req_ready", bus.refill_req_ready, 1'b1);
        check_output("cc wb_req_ready", bus.wb_req_ready, 1'b1);
        tick();
        bus.refill_req_valid = 1'b0;
        bus.wb_req_valid     = 1'b0;
        check_output("cc rd_addr_valid", bus.rd_addr_to_l2_valid, 1'b1);
        check_output("cc rd_addr", bus.rd_addr_to_l2, 30'h100);
        check_output("cc wr_valid", bus.wr_to_l2_valid, 1'b1);
        check_output("cc wr_control beat0", bus.wr_control_to_l2, 1'b1);
        check_output("cc wr_addr", bus.wr_addr_to_l2, 30'h400);
        check_output("cc data_to_l2 beat0", bus.data_to_l2, wb_beats[0]);
        bus.rd_addr_to_l2_ready = 1'b1;
        bus.wr_to_l2_ready      = 1'b1;
        tick();
        bus.rd_addr_to_l2_ready = 1'b0;
        check_output("cc rd_addr_valid after handshake", bus.rd_addr_to_l2_valid, 1'b0);
        check_output("cc wr_control beat1", bus.wr_control_to_l2, 1'b0);
        check_output("cc data_to_l2 beat1", bus.data_to_l2, wb_beats[1]);
        feed_read_beats(4);
        bus.wr_to_l2_ready = 1'b0;
        check_output("cc wr_valid after burst", bus.wr_to_l2_valid, 1'b0);
        check_output("cc wb_req_ready waiting", bus.wb_req_ready, 1'b0);
        finish_refill("cc");
        bus.wr_complete = 1'b1;
        tick();
        bus.wr_complete = 1'b0;
        check_output("cc wb_req_ready after commit", bus.wb_req_ready, 1'b1);
        check_output("cc proto_err", bus.proto_err, 1'b0);

        // Stray read beat while idle: flag sticks, line untouched
        bus.data_from_l2_valid = 1'b1;
        bus.data_from_l2       = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
        tick();
        bus.data_from_l2_valid = 1'b0;
        bus.data_from_l2       = '0;
        check_output("pe proto_err set", bus.proto_err, 1'b1);
        repeat (3) tick();
        check_output("pe proto_err sticky", bus.proto_err, 1'b1);
        check_output("pe refill_valid", bus.refill_valid, 1'b0);
        check_output("pe line unchanged", bus.refill_line,
                     {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});

        // Reset after three beats of a refill, then a clean refill
        rd_beats[0] = 128'h0BAD0000_0BAD0000_0BAD0000_0BAD0000;
        rd_beats[1] = 128'h0BAD0001_0BAD0001_0BAD0001_0BAD0001;
        rd_beats[2] = 128'h0BAD0002_0BAD0002_0BAD0002_0BAD0002;
        rd_beats[3] = 128'h0BAD0003_0BAD0003_0BAD0003_0BAD0003;
        accept_refill("rs", 30'h500);
        address_phase("rs", 30'h500);
        feed_read_beats(3);
        rstn = 1'b0;
        #1;
        check_reset_values("mid-burst reset");
        #10;
        rstn = 1'b1;
        tick();
        rd_beats[0] = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
        rd_beats[1] = 128'h11223344_55667788_99AABBCC_DDEEFF00;
        rd_beats[2] = 128'hCAFEBABE_FACEFEED_01234567_89ABCDEF;
        rd_beats[3] = 128'h76543210_FEDCBA98_C0FFEE00_BADC0DE5;
        accept_refill("rs2", 30'h140);
        address_phase("rs2", 30'h140);
        feed_read_beats(4);
        finish_refill("rs2");
        check_output("rs2 proto_err", bus.proto_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
